// File: rtl/baser_stim_sequencer.sv
// Scenario-table stimulus sequencer for the PCS 257b generator/checker pair.
// Plays up to DEPTH TXD/TXC entries, each for a programmable number of cycles,
// waits a drain window, then issues a pass/fail verdict from the checker's
// block and invalid-block counter deltas.
module baser_stim_sequencer #(
   parameter int unsigned                 DATA_WIDTH    = 64,
   parameter int unsigned                 CONTROL_WIDTH = 8,
   parameter int unsigned                 DEPTH         = 16,
   parameter int unsigned                 HOLD_WIDTH    = 16,
   parameter int unsigned                 CNT_WIDTH     = 32,
   parameter logic [DATA_WIDTH-1:0]       IDLE_TXD      = 64'h0707070707070707,
   parameter logic [CONTROL_WIDTH-1:0]    IDLE_TXC      = 8'hFF
) (
   input  logic                           clk,
   input  logic                           i_rst_n,
   input  logic                           i_cfg_we,
   input  logic [$clog2(DEPTH)-1:0]       i_cfg_addr,
   input  logic [DATA_WIDTH-1:0]          i_cfg_txd,
   input  logic [CONTROL_WIDTH-1:0]       i_cfg_txc,
   input  logic [HOLD_WIDTH-1:0]          i_cfg_hold,
   input  logic [$clog2(DEPTH):0]         i_num_entries,
   input  logic [HOLD_WIDTH-1:0]          i_drain_cycles,
   input  logic                           i_start,
   input  logic                           i_abort,
   input  logic [CNT_WIDTH-1:0]           i_block_count,
   input  logic [CNT_WIDTH-1:0]           i_inv_block_count,
   output logic [DATA_WIDTH-1:0]          o_txd,
   output logic [CONTROL_WIDTH-1:0]       o_txc,
   output logic                           o_gen_enable,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_pass,
   output logic [$clog2(DEPTH)-1:0]       o_entry_idx,
   output logic [CNT_WIDTH-1:0]           o_blocks_seen,
   output logic [CNT_WIDTH-1:0]           o_inv_seen
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NW = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, CHECK} state_t;

   state_t state;
   state_t next_state;

   logic [DATA_WIDTH-1:0]    tab_txd  [DEPTH];
   logic [CONTROL_WIDTH-1:0] tab_txc  [DEPTH];
   logic [HOLD_WIDTH-1:0]    tab_hold [DEPTH];

   logic [NW-1:0]            num_lat;
   logic [HOLD_WIDTH-1:0]    drain_lat;
   logic [HOLD_WIDTH-1:0]    cnt;
   logic [CNT_WIDTH-1:0]     snap_blk;
   logic [CNT_WIDTH-1:0]     snap_inv;

   logic [NW-1:0]            num_eff;
   logic                     start_ok;
   logic                     cnt_zero;
   logic                     last_entry;
   logic [AW-1:0]            idx_next;
   logic [CNT_WIDTH-1:0]     blk_delta;
   logic [CNT_WIDTH-1:0]     inv_delta;

   // A hold or drain of 0 behaves as 1; the counter holds (cycles - 1).
   function automatic logic [HOLD_WIDTH-1:0] hold_to_count(input logic [HOLD_WIDTH-1:0] h);
      return (h == '0) ? '0 : h - HOLD_WIDTH'(1);
   endfunction

   assign num_eff    = (i_num_entries > NW'(DEPTH)) ? NW'(DEPTH) : i_num_entries;
   assign start_ok   = i_start && !i_abort;
   assign cnt_zero   = (cnt == '0);
   assign last_entry = ({1'b0, o_entry_idx} == (num_lat - NW'(1)));
   assign idx_next   = o_entry_idx + AW'(1);
   assign blk_delta  = i_block_count - snap_blk;
   assign inv_delta  = i_inv_block_count - snap_inv;

   // Scenario table: writable only while idle, contents not reset.
   always_ff @(posedge clk) begin
      if (i_cfg_we && (state == IDLE)) begin
         tab_txd[i_cfg_addr]  <= i_cfg_txd;
         tab_txc[i_cfg_addr]  <= i_cfg_txc;
         tab_hold[i_cfg_addr] <= i_cfg_hold;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; abort overrides any other transition.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start_ok) begin
               next_state = (num_eff == '0) ? CHECK : RUN;
            end
         end
         RUN: begin
            if (i_abort) begin
               next_state = IDLE;
            end else if (cnt_zero && last_entry) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (i_abort) begin
               next_state = IDLE;
            end else if (cnt_zero) begin
               next_state = CHECK;
            end
         end
         CHECK: begin
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      o_busy       = (state != IDLE);
      o_done       = (state == CHECK);
      o_gen_enable = 1'b0;
   end

   // Datapath: drive pattern, sequence entries, count holds, compute verdict.
   // Deltas are registered on the edge into CHECK so they are valid together
   // with o_done; the counters are therefore sampled in the last DRAIN cycle.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_txd         <= IDLE_TXD;
         o_txc         <= IDLE_TXC;
         o_pass        <= 1'b0;
         o_entry_idx   <= '0;
         o_blocks_seen <= '0;
         o_inv_seen    <= '0;
         num_lat       <= '0;
         drain_lat     <= '0;
         cnt           <= '0;
         snap_blk      <= '0;
         snap_inv      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_ok) begin
                  o_pass      <= 1'b0;
                  o_entry_idx <= '0;
                  if (num_eff == '0) begin
                     o_blocks_seen <= '0;
                     o_inv_seen    <= '0;
                  end else begin
                     num_lat   <= num_eff;
                     drain_lat <= i_drain_cycles;
                     snap_blk  <= i_block_count;
                     snap_inv  <= i_inv_block_count;
                     o_txd     <= tab_txd[0];
                     o_txc     <= tab_txc[0];
                     cnt       <= hold_to_count(tab_hold[0]);
                  end
               end
            end
            RUN: begin
               if (i_abort) begin
                  o_txd       <= IDLE_TXD;
                  o_txc       <= IDLE_TXC;
                  o_pass      <= 1'b0;
                  o_entry_idx <= '0;
               end else if (cnt_zero) begin
                  if (last_entry) begin
                     o_txd <= IDLE_TXD;
                     o_txc <= IDLE_TXC;
                     cnt   <= hold_to_count(drain_lat);
                  end else begin
                     o_entry_idx <= idx_next;
                     o_txd       <= tab_txd[idx_next];
                     o_txc       <= tab_txc[idx_next];
                     cnt         <= hold_to_count(tab_hold[idx_next]);
                  end
               end else begin
                  cnt <= cnt - HOLD_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (i_abort) begin
                  o_pass      <= 1'b0;
                  o_entry_idx <= '0;
               end else if (cnt_zero) begin
                  o_blocks_seen <= blk_delta;
                  o_inv_seen    <= inv_delta;
                  o_pass        <= (inv_delta == '0) && (blk_delta != '0);
               end else begin
                  cnt <= cnt - HOLD_WIDTH'(1);
               end
            end
            CHECK: begin
               o_entry_idx <= '0;
               if (i_abort) begin
                  o_pass <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_baser_stim_sequencer.sv
// Self-checking bench for baser_stim_sequencer: a schedule-based reference
// model (per-cycle expected output queue built at start) checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_baser_stim_sequencer;

   localparam logic [63:0] IDLE_TXD = 64'h0707070707070707;
   localparam logic [7:0]  IDLE_TXC = 8'hFF;
   localparam logic [63:0] E0_TXD   = 64'hFFFFFFFFFFFFFFFF;
   localparam logic [63:0] E1_TXD   = 64'h07070707070707FD;
   localparam logic [63:0] E2_TXD   = 64'hAAAAAAAAAAAAAAFB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [63:0] cfg_txd = '0;
   logic [7:0]  cfg_txc = '0;
   logic [15:0] cfg_hold = '0;
   logic [4:0]  num = '0;
   logic [15:0] drain = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] blk_cnt = '0;
   logic [31:0] inv_cnt = '0;

   logic [63:0] o_txd;
   logic [7:0]  o_txc;
   logic        o_gen_enable, o_busy, o_done, o_pass;
   logic [3:0]  o_entry_idx;
   logic [31:0] o_blocks_seen, o_inv_seen;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   bit          cnt_auto = 1'b0;
   logic [63:0] obs [128];

   always #5 clk = ~clk;

   baser_stim_sequencer #(
      .DATA_WIDTH(64), .CONTROL_WIDTH(8), .DEPTH(16), .HOLD_WIDTH(16), .CNT_WIDTH(32),
      .IDLE_TXD(IDLE_TXD), .IDLE_TXC(IDLE_TXC)
   ) dut (
      .clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
      .i_cfg_txd(cfg_txd), .i_cfg_txc(cfg_txc), .i_cfg_hold(cfg_hold),
      .i_num_entries(num), .i_drain_cycles(drain), .i_start(start), .i_abort(abort),
      .i_block_count(blk_cnt), .i_inv_block_count(inv_cnt),
      .o_txd(o_txd), .o_txc(o_txc), .o_gen_enable(o_gen_enable), .o_busy(o_busy),
      .o_done(o_done), .o_pass(o_pass), .o_entry_idx(o_entry_idx),
      .o_blocks_seen(o_blocks_seen), .o_inv_seen(o_inv_seen)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          chk;
      bit          run;
      logic [63:0] txd;
      logic [7:0]  txc;
      logic [3:0]  idx;
   } item_t;

   item_t       sched [$];
   item_t       cur;
   bit          cur_v = 1'b0;
   bit          zero_run = 1'b0;
   logic [63:0] sh_txd  [16];
   logic [7:0]  sh_txc  [16];
   logic [15:0] sh_hold [16];
   logic [31:0] m_snap_blk = '0, m_snap_inv = '0;
   logic [63:0] e_txd = IDLE_TXD;
   logic [7:0]  e_txc = IDLE_TXC;
   bit          e_busy = 1'b0, e_done = 1'b0, e_pass = 1'b0, e_idx_v = 1'b0;
   logic [31:0] e_blk = '0, e_inv = '0;
   logic [3:0]  e_idx = '0;

   task automatic model_reset();
      sched.delete();
      cur_v = 1'b0; e_txd = IDLE_TXD; e_txc = IDLE_TXC;
      e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0; e_idx_v = 1'b0;
      e_blk = '0; e_inv = '0;
   endtask

   task automatic push_item(input bit c, input bit r, input logic [63:0] d,
                            input logic [7:0] k, input logic [3:0] i);
      item_t it;
      it.chk = c; it.run = r; it.txd = d; it.txc = k; it.idx = i;
      sched.push_back(it);
   endtask

   task automatic model_step();
      int n;
      int reps;
      if (!cur_v) begin
         if (start && !abort) begin
            n = (int'(num) > 16) ? 16 : int'(num);
            e_pass = 1'b0;
            m_snap_blk = blk_cnt;
            m_snap_inv = inv_cnt;
            zero_run = (n == 0);
            for (int e = 0; e < n; e++) begin
               reps = (sh_hold[e] == 16'd0) ? 1 : int'(sh_hold[e]);
               for (int k = 0; k < reps; k++) push_item(1'b0, 1'b1, sh_txd[e], sh_txc[e], 4'(e));
            end
            if (n > 0) begin
               reps = (drain == 16'd0) ? 1 : int'(drain);
               for (int k = 0; k < reps; k++) push_item(1'b0, 1'b0, IDLE_TXD, IDLE_TXC, 4'd0);
            end
            push_item(1'b1, 1'b0, IDLE_TXD, IDLE_TXC, 4'd0);
         end
         if (cfg_we) begin
            sh_txd[cfg_addr] = cfg_txd;
            sh_txc[cfg_addr] = cfg_txc;
            sh_hold[cfg_addr] = cfg_hold;
         end
      end else if (abort) begin
         sched.delete();
         e_pass = 1'b0;
      end
      if (sched.size() > 0) begin
         cur = sched.pop_front();
         cur_v = 1'b1;
      end else begin
         cur_v = 1'b0;
      end
      e_busy  = cur_v;
      e_done  = cur_v && cur.chk;
      e_idx_v = cur_v && cur.run;
      e_idx   = cur.idx;
      e_txd   = (cur_v && cur.run) ? cur.txd : IDLE_TXD;
      e_txc   = (cur_v && cur.run) ? cur.txc : IDLE_TXC;
      if (e_done) begin
         if (zero_run) begin
            e_blk = '0; e_inv = '0; e_pass = 1'b0;
         end else begin
            e_blk = blk_cnt - m_snap_blk;
            e_inv = inv_cnt - m_snap_inv;
            e_pass = (e_inv == 32'd0) && (e_blk != 32'd0);
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check("txd", o_txd, e_txd);
         check("txc", {56'd0, o_txc}, {56'd0, e_txc});
         check("busy", {63'd0, o_busy}, {63'd0, e_busy});
         check("done", {63'd0, o_done}, {63'd0, e_done});
         check("pass", {63'd0, o_pass}, {63'd0, e_pass});
         check("blocks_seen", {32'd0, o_blocks_seen}, {32'd0, e_blk});
         check("inv_seen", {32'd0, o_inv_seen}, {32'd0, e_inv});
         check("gen_enable", {63'd0, o_gen_enable}, 64'd0);
         if (e_idx_v) check("entry_idx", {60'd0, o_entry_idx}, {60'd0, e_idx});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
      if (cnt_auto) blk_cnt = blk_cnt + 32'd1;
   endtask

   task automatic write_entry(input logic [3:0] a, input logic [63:0] d,
                              input logic [7:0] k, input logic [15:0] h);
      cfg_we = 1'b1; cfg_addr = a; cfg_txd = d; cfg_txc = k; cfg_hold = h;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic load_table();
      write_entry(4'd0, E0_TXD, 8'h00, 16'd4);
      write_entry(4'd1, E1_TXD, 8'hFF, 16'd2);
      write_entry(4'd2, E2_TXD, 8'h01, 16'd3);
      for (int i = 3; i < 16; i++) write_entry(4'(i), {16{4'(i)}}, 8'(i), 16'(i % 3));
   endtask

   task automatic run_and_wait(input int limit, input int inj_cyc, input logic [31:0] inv_add,
                               input bit blk_set, input logic [31:0] blk_val, output int done_cyc);
      int cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      obs[1] = o_txd;
      while (o_done !== 1'b1 && cyc < limit) begin
         if (cyc == inj_cyc) begin
            inv_cnt = inv_cnt + inv_add;
            if (blk_set) blk_cnt = blk_val;
         end
         step();
         cyc++;
         if (cyc < 128) obs[cyc] = o_txd;
      end
      check("done_within_budget", {63'd0, o_done}, 64'd1);
      done_cyc = cyc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  dc;
      bit  done_any;
      repeat (2) @(negedge clk);
      check("rst_txd", o_txd, IDLE_TXD);
      check("rst_txc", {56'd0, o_txc}, {56'd0, IDLE_TXC});
      check("rst_busy", {63'd0, o_busy}, 64'd0);
      check("rst_done", {63'd0, o_done}, 64'd0);
      check("rst_pass", {63'd0, o_pass}, 64'd0);
      check("rst_idx", {60'd0, o_entry_idx}, 64'd0);
      check("rst_blocks", {32'd0, o_blocks_seen}, 64'd0);
      rst_n = 1'b1;
      load_table();

      // Three-entry run, drain 50.
      cnt_auto = 1'b1; num = 5'd3; drain = 16'd50;
      run_and_wait(200, -1, 32'd0, 1'b0, 32'd0, dc);
      check("t1_done_cycle", 64'(dc), 64'd60);
      check("t1_c1", obs[1], E0_TXD);
      check("t1_c4", obs[4], E0_TXD);
      check("t1_c5", obs[5], E1_TXD);
      check("t1_c6", obs[6], E1_TXD);
      check("t1_c7", obs[7], E2_TXD);
      check("t1_c9", obs[9], E2_TXD);
      check("t1_c10", obs[10], IDLE_TXD);
      check("t1_pass", {63'd0, o_pass}, 64'd1);
      check("t1_inv", {32'd0, o_inv_seen}, 64'd0);
      step();

      // Same run with two invalid blocks injected mid-run.
      run_and_wait(200, 5, 32'd2, 1'b0, 32'd0, dc);
      check("t2_inv", {32'd0, o_inv_seen}, 64'd2);
      check("t2_pass", {63'd0, o_pass}, 64'd0);
      step();

      // Empty run.
      num = 5'd0;
      run_and_wait(10, -1, 32'd0, 1'b0, 32'd0, dc);
      check("t3_done_cycle", 64'(dc), 64'd1);
      check("t3_pass", {63'd0, o_pass}, 64'd0);
      check("t3_blocks", {32'd0, o_blocks_seen}, 64'd0);
      step();

      // Block counter wrap between snapshot and check.
      cnt_auto = 1'b0; blk_cnt = 32'hFFFFFFF0; num = 5'd1; drain = 16'd3;
      run_and_wait(50, 2, 32'd0, 1'b1, 32'h00000010, dc);
      check("t4_done_cycle", 64'(dc), 64'd8);
      check("t4_blocks", {32'd0, o_blocks_seen}, 64'd32);
      check("t4_pass", {63'd0, o_pass}, 64'd1);
      step();

      // Abort at entry 1, with an ignored table write in the same cycle.
      cnt_auto = 1'b1; num = 5'd3; drain = 16'd10;
      start = 1'b1;
      step();
      start = 1'b0;
      dc = 1;
      while (o_entry_idx !== 4'd1 && dc < 20) begin
         step();
         dc++;
      end
      check("t5_reached_entry1", {60'd0, o_entry_idx}, 64'd1);
      abort = 1'b1;
      cfg_we = 1'b1; cfg_addr = 4'd1; cfg_txd = 64'hDEADBEEFDEADBEEF; cfg_txc = 8'h5A; cfg_hold = 16'd7;
      step();
      abort = 1'b0; cfg_we = 1'b0;
      check("t5_busy", {63'd0, o_busy}, 64'd0);
      check("t5_txd", o_txd, IDLE_TXD);
      check("t5_pass", {63'd0, o_pass}, 64'd0);
      done_any = 1'b0;
      for (int i = 0; i < 20; i++) begin
         done_any |= o_done;
         step();
      end
      check("t5_no_done", {63'd0, done_any}, 64'd0);
      drain = 16'd50;
      run_and_wait(200, -1, 32'd0, 1'b0, 32'd0, dc);
      check("t5_rerun_done_cycle", 64'(dc), 64'd60);
      check("t5_entry1_kept_c5", obs[5], E1_TXD);
      check("t5_entry1_kept_c6", obs[6], E1_TXD);
      step();

      // Reset asserted mid-drain, then a fresh run.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (15) step();
      #2 rst_n = 1'b0;
      #1;
      check("t6_txd", o_txd, IDLE_TXD);
      check("t6_busy", {63'd0, o_busy}, 64'd0);
      check("t6_blocks", {32'd0, o_blocks_seen}, 64'd0);
      check("t6_inv", {32'd0, o_inv_seen}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      load_table();
      run_and_wait(200, -1, 32'd0, 1'b0, 32'd0, dc);
      check("t6_rerun_done_cycle", 64'(dc), 64'd60);
      check("t6_rerun_pass", {63'd0, o_pass}, 64'd1);
      step();

      // Randomized traffic.
      cnt_auto = 1'b0;
      blk_cnt = 32'hFFFFFF00;
      for (int i = 0; i < 3000; i++) begin
         start    = ($urandom % 8) == 0;
         abort    = ($urandom % 40) == 0;
         cfg_we   = !start && (($urandom % 4) == 0);
         cfg_addr = 4'($urandom);
         cfg_txd  = {$urandom, $urandom};
         cfg_txc  = 8'($urandom);
         cfg_hold = 16'($urandom % 4);
         num      = 5'($urandom % 21);
         drain    = 16'($urandom % 5);
         blk_cnt  = blk_cnt + 32'($urandom % 2);
         if (($urandom % 30) == 0) inv_cnt = inv_cnt + 32'd1;
         step();
      end
      start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      repeat (100) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
